// File: rtl/tank_pkg.sv
// Shared types and default keycodes for the keyboard-steered tank and its bullet pool.
package tank_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef struct packed {
    logic       active;
    logic [9:0] x;
    logic [9:0] y;
    dir_t       dir;
  } bullet_t;

  localparam logic [7:0] KEY_UP_DEF    = 8'h1A;
  localparam logic [7:0] KEY_RIGHT_DEF = 8'h07;
  localparam logic [7:0] KEY_DOWN_DEF  = 8'h16;
  localparam logic [7:0] KEY_LEFT_DEF  = 8'h04;
  localparam logic [7:0] KEY_FIRE_DEF  = 8'h58;

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: captures a spawn, advances every tick, retires at the field edge.
module bullet_slot
  import tank_pkg::*;
#(
  parameter int unsigned X_MAX       = 639,
  parameter int unsigned Y_MAX       = 479,
  parameter int unsigned BULLET_SIZE = 4,
  parameter int unsigned BULLET_STEP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       spawn,
  input  logic [9:0] spawn_x,
  input  logic [9:0] spawn_y,
  input  dir_t       spawn_dir,
  input  logic [9:0] draw_x,
  input  logic [9:0] draw_y,
  output bullet_t    state,
  output logic       retire,
  output logic       hit
);

  localparam logic [10:0] Step  = 11'(BULLET_STEP);
  localparam logic [10:0] Size  = 11'(BULLET_SIZE);
  // Largest coordinate from which one more step still keeps the bullet in-field.
  localparam logic [10:0] XLast = 11'(X_MAX + 1 - BULLET_SIZE - BULLET_STEP);
  localparam logic [10:0] YLast = 11'(Y_MAX + 1 - BULLET_SIZE - BULLET_STEP);

  logic [10:0] x_w, y_w, dx_w, dy_w;
  logic        leaving;
  bullet_t     state_d;

  assign x_w  = {1'b0, state.x};
  assign y_w  = {1'b0, state.y};
  assign dx_w = {1'b0, draw_x};
  assign dy_w = {1'b0, draw_y};

  always_comb begin
    leaving = 1'b0;
    case (state.dir)
      UP:      leaving = y_w < Step;
      RIGHT:   leaving = x_w > XLast;
      DOWN:    leaving = y_w > YLast;
      LEFT:    leaving = x_w < Step;
      default: leaving = 1'b0;
    endcase
  end

  assign retire = tick && state.active && leaving;

  always_comb begin
    state_d = state;
    if (spawn) begin
      state_d.active = 1'b1;
      state_d.x      = spawn_x;
      state_d.y      = spawn_y;
      state_d.dir    = spawn_dir;
    end else if (tick && state.active) begin
      if (leaving) begin
        state_d.active = 1'b0;
      end else begin
        case (state.dir)
          UP:      state_d.y = 10'(y_w - Step);
          RIGHT:   state_d.x = 10'(x_w + Step);
          DOWN:    state_d.y = 10'(y_w + Step);
          LEFT:    state_d.x = 10'(x_w - Step);
          default: state_d = state;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= '0;
    end else begin
      state <= state_d;
    end
  end

  assign hit = state.active
             && (dx_w >= x_w) && (dx_w < x_w + Size)
             && (dy_w >= y_w) && (dy_w < y_w + Size);

endmodule

// File: rtl/tank_bullet_pool.sv
// Keyboard-steered tank with clamped movement and a pool of independent bullets.
module tank_bullet_pool
  import tank_pkg::*;
#(
  parameter int unsigned X_START     = 500,
  parameter int unsigned Y_START     = 240,
  parameter int unsigned X_MAX       = 639,
  parameter int unsigned Y_MAX       = 479,
  parameter int unsigned TANK_SIZE   = 32,
  parameter int unsigned BULLET_SIZE = 4,
  parameter int unsigned TANK_STEP   = 1,
  parameter int unsigned BULLET_STEP = 4,
  parameter int unsigned NUM_BULLETS = 4,
  parameter int unsigned COOLDOWN    = 15,
  parameter logic [7:0]  KEY_UP      = KEY_UP_DEF,
  parameter logic [7:0]  KEY_RIGHT   = KEY_RIGHT_DEF,
  parameter logic [7:0]  KEY_DOWN    = KEY_DOWN_DEF,
  parameter logic [7:0]  KEY_LEFT    = KEY_LEFT_DEF,
  parameter logic [7:0]  KEY_FIRE    = KEY_FIRE_DEF
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   frame_clk,
  input  logic [7:0]             keycode,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  output logic [9:0]             tank_X,
  output logic [9:0]             tank_Y,
  output dir_t                   tank_dir,
  output logic                   is_tank,
  output logic                   is_bullet,
  output logic [NUM_BULLETS-1:0] bullet_active,
  output logic                   shot_fired,
  output logic                   wall_hit
);

  localparam logic [10:0] TankStep   = 11'(TANK_STEP);
  localparam logic [10:0] TankSize   = 11'(TANK_SIZE);
  localparam logic [10:0] BulletSize = 11'(BULLET_SIZE);
  localparam logic [10:0] Centre     = 11'((TANK_SIZE - BULLET_SIZE) / 2);
  localparam logic [10:0] XLim       = 11'(X_MAX + 1 - TANK_SIZE);
  localparam logic [10:0] YLim       = 11'(Y_MAX + 1 - TANK_SIZE);
  localparam logic [10:0] FieldW     = 11'(X_MAX + 1);
  localparam logic [10:0] FieldH     = 11'(Y_MAX + 1);
  localparam int unsigned CdW        = $clog2(COOLDOWN + 2);

  // frame_clk crosses into Clk through two flops before edge detection.
  logic fc_meta, fc_sync, fc_prev, tick;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fc_meta <= 1'b0;
      fc_sync <= 1'b0;
      fc_prev <= 1'b0;
      tick    <= 1'b0;
    end else begin
      fc_meta <= frame_clk;
      fc_sync <= fc_meta;
      fc_prev <= fc_sync;
      tick    <= fc_sync & ~fc_prev;
    end
  end

  logic [10:0] tx_w, ty_w, dx_w, dy_w;
  logic [9:0]  tx_d, ty_d;
  dir_t        dir_d;

  assign tx_w = {1'b0, tank_X};
  assign ty_w = {1'b0, tank_Y};
  assign dx_w = {1'b0, DrawX};
  assign dy_w = {1'b0, DrawY};

  always_comb begin
    tx_d  = tank_X;
    ty_d  = tank_Y;
    dir_d = tank_dir;
    if (keycode == KEY_UP) begin
      dir_d = UP;
      ty_d  = (ty_w < TankStep) ? '0 : 10'(ty_w - TankStep);
    end else if (keycode == KEY_RIGHT) begin
      dir_d = RIGHT;
      tx_d  = (tx_w + TankStep > XLim) ? XLim[9:0] : 10'(tx_w + TankStep);
    end else if (keycode == KEY_DOWN) begin
      dir_d = DOWN;
      ty_d  = (ty_w + TankStep > YLim) ? YLim[9:0] : 10'(ty_w + TankStep);
    end else if (keycode == KEY_LEFT) begin
      dir_d = LEFT;
      tx_d  = (tx_w < TankStep) ? '0 : 10'(tx_w - TankStep);
    end
  end

  logic [9:0] muzzle_x, muzzle_y;
  logic       muzzle_ok;

  always_comb begin
    muzzle_x  = 10'(tx_w + Centre);
    muzzle_y  = 10'(ty_w + Centre);
    muzzle_ok = 1'b0;
    case (tank_dir)
      UP: begin
        muzzle_y  = 10'(ty_w - BulletSize);
        muzzle_ok = ty_w >= BulletSize;
      end
      RIGHT: begin
        muzzle_x  = 10'(tx_w + TankSize);
        muzzle_ok = tx_w + TankSize + BulletSize <= FieldW;
      end
      DOWN: begin
        muzzle_y  = 10'(ty_w + TankSize);
        muzzle_ok = ty_w + TankSize + BulletSize <= FieldH;
      end
      LEFT: begin
        muzzle_x  = 10'(tx_w - BulletSize);
        muzzle_ok = tx_w >= BulletSize;
      end
      default: muzzle_ok = 1'b0;
    endcase
  end

  logic [CdW-1:0]         cooldown;
  logic                   prev_fire, fire;
  logic [NUM_BULLETS-1:0] free_slots, first_free, spawn, retire, hit;

  // Allocation uses the pre-tick free map, so a slot retiring this tick is not reused.
  assign free_slots = ~bullet_active;
  assign first_free = free_slots & (~free_slots + NUM_BULLETS'(1));
  assign fire       = tick && (keycode == KEY_FIRE) && !prev_fire && (cooldown == '0)
                      && (|free_slots) && muzzle_ok;
  assign spawn      = fire ? first_free : '0;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tank_X     <= 10'(X_START);
      tank_Y     <= 10'(Y_START);
      tank_dir   <= UP;
      cooldown   <= '0;
      prev_fire  <= 1'b0;
      shot_fired <= 1'b0;
      wall_hit   <= 1'b0;
    end else begin
      shot_fired <= fire;
      wall_hit   <= |retire;
      if (tick) begin
        tank_X    <= tx_d;
        tank_Y    <= ty_d;
        tank_dir  <= dir_d;
        prev_fire <= (keycode == KEY_FIRE);
        if (fire) begin
          cooldown <= CdW'(COOLDOWN);
        end else if (cooldown != '0) begin
          cooldown <= cooldown - CdW'(1);
        end
      end
    end
  end

  bullet_t slots [NUM_BULLETS];

  for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
    bullet_slot #(
      .X_MAX       (X_MAX),
      .Y_MAX       (Y_MAX),
      .BULLET_SIZE (BULLET_SIZE),
      .BULLET_STEP (BULLET_STEP)
    ) u_slot (
      .clk       (Clk),
      .rst       (Reset),
      .tick      (tick),
      .spawn     (spawn[i]),
      .spawn_x   (muzzle_x),
      .spawn_y   (muzzle_y),
      .spawn_dir (tank_dir),
      .draw_x    (DrawX),
      .draw_y    (DrawY),
      .state     (slots[i]),
      .retire    (retire[i]),
      .hit       (hit[i])
    );
    assign bullet_active[i] = slots[i].active;
  end

  assign is_tank   = (dx_w >= tx_w) && (dx_w < tx_w + TankSize)
                  && (dy_w >= ty_w) && (dy_w < ty_w + TankSize);
  assign is_bullet = |hit;

endmodule

// File: tb/tb_tank_bullet_pool.sv
// Bench for tank_bullet_pool: directed table, multi-tick corner sequences, random vs model.
module tb_tank_bullet_pool;
  import tank_pkg::*;

  localparam int NB      = 4;
  localparam int FIELD_W = 640;
  localparam int FIELD_H = 480;
  localparam int TSIZE   = 32;
  localparam int BSIZE   = 4;
  localparam int TSTEP   = 1;
  localparam int BSTEP   = 4;
  localparam int CD      = 15;
  localparam logic [7:0] K_UP = 8'h1A, K_RIGHT = 8'h07, K_DOWN = 8'h16;
  localparam logic [7:0] K_LEFT = 8'h04, K_FIRE = 8'h58;

  logic          Clk = 1'b0;
  logic          Reset, frame_clk;
  logic [7:0]    keycode;
  logic [9:0]    DrawX, DrawY, tank_X, tank_Y;
  dir_t          tank_dir;
  logic          is_tank, is_bullet, shot_fired, wall_hit;
  logic [NB-1:0] bullet_active;

  tank_bullet_pool dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_clk     (frame_clk),
    .keycode       (keycode),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .tank_X        (tank_X),
    .tank_Y        (tank_Y),
    .tank_dir      (tank_dir),
    .is_tank       (is_tank),
    .is_bullet     (is_bullet),
    .bullet_active (bullet_active),
    .shot_fired    (shot_fired),
    .wall_hit      (wall_hit)
  );

  always #10 Clk = ~Clk;

  int checks = 0, errors = 0;
  int shot_seen, hit_seen, exp_shot, exp_hit, tot_shots, tot_hits;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference model: positions as plain integers, moves as direction unit vectors.
  int m_tx, m_ty, m_dir, m_cd;
  bit m_prev;
  bit m_act [NB];
  int m_bx [NB], m_by [NB], m_bd [NB];

  function automatic int dxf(input int d);
    return (d == 1) ? 1 : (d == 3) ? -1 : 0;
  endfunction
  function automatic int dyf(input int d);
    return (d == 2) ? 1 : (d == 0) ? -1 : 0;
  endfunction
  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction
  function automatic bit in_sq(input int px, input int py, input int x, input int y, input int s);
    return px >= x && px < x + s && py >= y && py < y + s;
  endfunction

  task automatic model_reset();
    m_tx = 500; m_ty = 240; m_dir = 0; m_cd = 0; m_prev = 0;
    for (int i = 0; i < NB; i++) m_act[i] = 0;
  endtask

  task automatic model_tick(input logic [7:0] key, output int shot, output int hit);
    bit was_free [NB];
    int nx, ny, slot, mx, my, d;
    shot = 0;
    hit  = 0;
    for (int i = 0; i < NB; i++) was_free[i] = !m_act[i];
    for (int i = 0; i < NB; i++) begin
      if (m_act[i]) begin
        nx = m_bx[i] + BSTEP * dxf(m_bd[i]);
        ny = m_by[i] + BSTEP * dyf(m_bd[i]);
        if (nx < 0 || nx > FIELD_W - BSIZE || ny < 0 || ny > FIELD_H - BSIZE) begin
          m_act[i] = 0;
          hit = 1;
        end else begin
          m_bx[i] = nx;
          m_by[i] = ny;
        end
      end
    end
    slot = -1;
    for (int i = NB - 1; i >= 0; i--) if (was_free[i]) slot = i;
    // Bullet is centred on the tank and pushed just outside it in the facing direction.
    mx = m_tx + (TSIZE - BSIZE) / 2 + dxf(m_dir) * ((TSIZE + BSIZE) / 2);
    my = m_ty + (TSIZE - BSIZE) / 2 + dyf(m_dir) * ((TSIZE + BSIZE) / 2);
    if (key == K_FIRE && !m_prev && m_cd == 0 && slot >= 0 && mx >= 0
        && mx <= FIELD_W - BSIZE && my >= 0 && my <= FIELD_H - BSIZE) begin
      shot = 1;
      m_act[slot] = 1; m_bx[slot] = mx; m_by[slot] = my; m_bd[slot] = m_dir;
      m_cd = CD;
    end else if (m_cd > 0) begin
      m_cd--;
    end
    m_prev = (key == K_FIRE);
    d = (key == K_UP) ? 0 : (key == K_RIGHT) ? 1 : (key == K_DOWN) ? 2 : (key == K_LEFT) ? 3 : -1;
    if (d >= 0) begin
      m_dir = d;
      m_tx = clampi(m_tx + TSTEP * dxf(d), 0, FIELD_W - TSIZE);
      m_ty = clampi(m_ty + TSTEP * dyf(d), 0, FIELD_H - TSIZE);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; frame_clk = 1'b0; keycode = 8'h00; DrawX = '0; DrawY = '0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    model_reset();
    tot_shots = 0;
    tot_hits  = 0;
  endtask

  // One frame: raise frame_clk, collect output pulses over 8 Clk, end at posedge+1.
  task automatic frame(input logic [7:0] key);
    keycode = key;
    model_tick(key, exp_shot, exp_hit);
    shot_seen = 0;
    hit_seen  = 0;
    frame_clk = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge Clk);
      #1;
      shot_seen += int'(shot_fired);
      hit_seen  += int'(wall_hit);
      if (c == 3) frame_clk = 1'b0;
    end
    tot_shots += shot_seen;
    tot_hits  += hit_seen;
  endtask

  function automatic int model_act();
    int v = 0;
    for (int i = 0; i < NB; i++) if (m_act[i]) v |= (1 << i);
    return v;
  endfunction

  task automatic compare_model();
    check("rnd_x", int'(tank_X), m_tx);
    check("rnd_y", int'(tank_Y), m_ty);
    check("rnd_dir", int'(tank_dir), m_dir);
    check("rnd_active", int'(bullet_active), model_act());
    check("rnd_shot", shot_seen, exp_shot);
    check("rnd_wall", hit_seen, exp_hit);
  endtask

  task automatic render_check();
    int idx, tx, ty, span, px, py, eb;
    idx = int'($urandom_range(0, NB));
    if (idx < NB && m_act[idx]) begin
      tx = m_bx[idx]; ty = m_by[idx]; span = BSIZE;
    end else begin
      tx = m_tx; ty = m_ty; span = TSIZE;
    end
    px = (tx + int'($urandom_range(0, span + 1)) - 1) & 1023;
    py = (ty + int'($urandom_range(0, span + 1)) - 1) & 1023;
    DrawX = px[9:0];
    DrawY = py[9:0];
    #1;
    eb = 0;
    for (int i = 0; i < NB; i++) if (m_act[i] && in_sq(px, py, m_bx[i], m_by[i], BSIZE)) eb = 1;
    check("rnd_is_tank", int'(is_tank), int'(in_sq(px, py, m_tx, m_ty, TSIZE)));
    check("rnd_is_bullet", int'(is_bullet), eb);
  endtask

  typedef struct {
    logic [7:0] key;
    int         ticks;
    int         ex, ey, ed, eact;
  } vec_t;

  logic [7:0] pool [8] = '{K_UP, K_RIGHT, K_DOWN, K_LEFT, K_FIRE, K_FIRE, 8'h00, 8'h33};

  initial begin
    vec_t tbl [8];
    int n, len, whits;
    logic [7:0] key;

    tbl[0] = '{K_RIGHT, 10, 510, 240, 1, 0};
    tbl[1] = '{8'h00,    3, 510, 240, 1, 0};
    tbl[2] = '{K_UP,     5, 510, 235, 0, 0};
    tbl[3] = '{K_LEFT,   2, 508, 235, 3, 0};
    tbl[4] = '{K_DOWN,   1, 508, 236, 2, 0};
    tbl[5] = '{8'h33,    2, 508, 236, 2, 0};
    tbl[6] = '{K_FIRE,   1, 508, 236, 2, 1};
    tbl[7] = '{K_RIGHT,  1, 509, 236, 1, 1};

    // Reset state and tank rendering edges.
    do_reset();
    check("rst_x", int'(tank_X), 500);
    check("rst_y", int'(tank_Y), 240);
    check("rst_dir", int'(tank_dir), 0);
    check("rst_active", int'(bullet_active), 0);
    check("rst_pulses", int'(shot_fired) + int'(wall_hit), 0);
    DrawX = 10'd500; DrawY = 10'd240; #1;
    check("tank_corner_in", int'(is_tank), 1);
    DrawX = 10'd531; DrawY = 10'd271; #1;
    check("tank_far_in", int'(is_tank), 1);
    DrawX = 10'd532; #1;
    check("tank_right_out", int'(is_tank), 0);
    DrawX = 10'd499; DrawY = 10'd250; #1;
    check("tank_left_out", int'(is_tank), 0);

    for (int r = 0; r < 8; r++) begin
      for (int t = 0; t < tbl[r].ticks; t++) frame(tbl[r].key);
      check("tbl_x", int'(tank_X), tbl[r].ex);
      check("tbl_y", int'(tank_Y), tbl[r].ey);
      check("tbl_dir", int'(tank_dir), tbl[r].ed);
      check("tbl_active", int'(bullet_active), tbl[r].eact);
    end

    // Right-edge clamp.
    do_reset();
    repeat (107) frame(K_RIGHT);
    check("clamp_607", int'(tank_X), 607);
    frame(K_RIGHT);
    check("clamp_608", int'(tank_X), 608);
    repeat (4) frame(K_RIGHT);
    check("clamp_hold", int'(tank_X), 608);

    // Held fire: one shot, bullet flight, wall retire.
    do_reset();
    frame(K_LEFT);
    frame(K_RIGHT);
    check("face_x", int'(tank_X), 500);
    check("face_dir", int'(tank_dir), 1);
    frame(K_FIRE);
    check("spawn_pulse", shot_seen, 1);
    check("spawn_active", int'(bullet_active), 1);
    DrawX = 10'd532; DrawY = 10'd254; #1;
    check("bullet_corner", int'(is_bullet), 1);
    DrawX = 10'd535; DrawY = 10'd257; #1;
    check("bullet_far", int'(is_bullet), 1);
    DrawX = 10'd536; #1;
    check("bullet_x_out", int'(is_bullet), 0);
    DrawX = 10'd533; DrawY = 10'd258; #1;
    check("bullet_y_out", int'(is_bullet), 0);
    for (int t = 1; t < 27; t++) frame(K_FIRE);
    check("flight_active", int'(bullet_active), 1);
    check("flight_no_wall", tot_hits, 0);
    frame(K_FIRE);
    check("retire_pulse", hit_seen, 1);
    check("retire_active", int'(bullet_active), 0);
    repeat (2) frame(K_FIRE);
    check("held_shots", tot_shots, 1);
    check("held_walls", tot_hits, 1);

    // Pool exhaustion.
    do_reset();
    frame(K_LEFT);
    for (int tap = 0; tap < 6; tap++) begin
      frame(K_FIRE);
      check("tap_shot", shot_seen, (tap < 4) ? 1 : 0);
      repeat (19) frame(8'h00);
    end
    check("pool_full", int'(bullet_active), 4'b1111);
    check("pool_shots", tot_shots, 4);

    // Cooldown blocks a quick second tap.
    do_reset();
    frame(K_FIRE);
    repeat (4) frame(8'h00);
    frame(K_FIRE);
    check("cd_blocked", shot_seen, 0);
    check("cd_active", int'(bullet_active), 1);
    check("cd_shots", tot_shots, 1);

    // Top edge: muzzle off-field, then reset mid-flight.
    do_reset();
    repeat (240) frame(K_UP);
    check("top_y", int'(tank_Y), 0);
    repeat (2) frame(K_UP);
    check("top_hold", int'(tank_Y), 0);
    frame(K_FIRE);
    check("muzzle_out", shot_seen, 0);
    check("muzzle_out_act", int'(bullet_active), 0);
    frame(K_DOWN);
    check("down_y", int'(tank_Y), 1);
    frame(K_FIRE);
    check("no_cd_after_out", shot_seen, 1);
    repeat (16) frame(8'h00);
    frame(K_FIRE);
    check("second_shot", shot_seen, 1);
    check("two_active", int'(bullet_active), 4'b0011);
    #2 Reset = 1'b1;
    #1;
    check("midrst_active", int'(bullet_active), 0);
    check("midrst_wall", int'(wall_hit), 0);
    check("midrst_y", int'(tank_Y), 240);
    whits = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge Clk);
      #1;
      whits += int'(wall_hit);
      if (c == 2) Reset = 1'b0;
    end
    check("midrst_wall_after", whits, 0);

    // Random key sequences against the model.
    do_reset();
    n = 0;
    while (n < 300) begin
      key = pool[$urandom_range(0, 7)];
      len = int'($urandom_range(1, 5));
      for (int k = 0; k < len; k++) begin
        frame(key);
        compare_model();
        render_check();
        n++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
